// File: rtl/pipeline_latealu_pkg.sv
// Shared definitions for the LateALU controller: ALU-stage op encodings,
// multiply FSM states and the operand magnitude helper.
package pipeline_latealu_pkg;

   localparam logic [5:0] LATEALU_OP_SRL  = 6'b000010;
   localparam logic [5:0] LATEALU_OP_SRA  = 6'b000011;
   localparam logic [5:0] LATEALU_OP_MULT = 6'b000100;
   localparam logic [5:0] LATEALU_OP_MTHI = 6'b000101;
   localparam logic [5:0] LATEALU_OP_MTLO = 6'b000110;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MUL_RUN = 2'd1,
      MUL_FIX = 2'd2
   } latealu_state_t;

   // 0x80000000 maps onto itself, which read as unsigned is exactly 2^31
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/latealu_iter_mult.sv
// Unsigned iterative 32x32 multiplier: retires STEP_BITS multiplier bits per
// step into a 64-bit accumulator; last_step flags the final iteration.
module latealu_iter_mult #(
   parameter int STEP_BITS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        step_en,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] acc,
   output logic        last_step
);

   localparam int ITER = 32 / STEP_BITS;
   localparam int CW   = $clog2(ITER) + 1;

   logic [63:0]   mcand;
   logic [31:0]   mplier;
   logic [CW-1:0] count;
   logic [63:0]   partial;

   // The multiplicand is pre-shifted each step, so no barrel shift by count is needed
   always_comb begin
      partial = mcand * {{(64-STEP_BITS){1'b0}}, mplier[STEP_BITS-1:0]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
      end else if (start) begin
         mcand  <= {32'd0, a};
         mplier <= b;
         acc    <= '0;
         count  <= '0;
      end else if (step_en) begin
         acc    <= acc + partial;
         mcand  <= mcand << STEP_BITS;
         mplier <= mplier >> STEP_BITS;
         count  <= count + 1'b1;
      end
   end

   assign last_step = (count == CW'(ITER - 1));

endmodule

// File: rtl/pipeline_latealu_ctrl.sv
// LateALU sequencer: single-cycle shifts, mthi/mtlo, and an iterative signed
// multiply that owns HI/LO and stalls the ALU stage while in flight.
module pipeline_latealu_ctrl
   import pipeline_latealu_pkg::*;
#(
   parameter int MULT_STEP_BITS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [5:0]  req_op,
   input  logic [31:0] req_a0,
   input  logic [31:0] req_a1,
   input  logic [4:0]  req_rd_index,
   input  logic        req_flush,
   input  logic        hilo_read,
   output logic        req_ready,
   output logic        stall,
   output logic        busy,
   output logic        wb_valid,
   output logic [4:0]  wb_index,
   output logic [31:0] wb_value,
   output logic [31:0] mult_hi,
   output logic [31:0] mult_lo,
   output logic        err
);

   latealu_state_t state, state_next;
   logic        accept;
   logic        mult_start;
   logic        step_en;
   logic        last_step;
   logic        neg;
   logic [63:0] acc;
   logic [63:0] product;
   logic [31:0] srl_val;
   logic [31:0] sra_val;

   assign busy      = (state != IDLE);
   assign req_ready = !busy;
   assign stall     = busy && (req_valid || hilo_read);
   assign accept    = req_valid && req_ready && !req_flush;

   assign srl_val = req_a0 >> req_a1[4:0];
   assign sra_val = $signed(req_a0) >>> req_a1[4:0];
   assign product = neg ? (64'd0 - acc) : acc;

   latealu_iter_mult #(
      .STEP_BITS (MULT_STEP_BITS)
   ) u_mult (
      .clk       (clk),
      .rst       (rst),
      .start     (mult_start),
      .step_en   (step_en),
      .a         (abs32(req_a0)),
      .b         (abs32(req_a1)),
      .acc       (acc),
      .last_step (last_step)
   );

   always_comb begin
      state_next = state;
      mult_start = 1'b0;
      step_en    = 1'b0;
      case (state)
         IDLE: begin
            if (accept && req_op == LATEALU_OP_MULT) begin
               mult_start = 1'b1;
               state_next = MUL_RUN;
            end
         end
         MUL_RUN: begin
            step_en = 1'b1;
            if (last_step) state_next = MUL_FIX;
         end
         MUL_FIX: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // HI/LO only change on MUL_FIX or an idle mthi/mtlo, never mid-multiply
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_valid <= 1'b0;
         wb_index <= '0;
         wb_value <= '0;
         mult_hi  <= '0;
         mult_lo  <= '0;
         err      <= 1'b0;
         neg      <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         err      <= 1'b0;
         if (state == MUL_FIX) begin
            {mult_hi, mult_lo} <= product;
         end else if (accept) begin
            case (req_op)
               LATEALU_OP_SRL: begin
                  wb_valid <= 1'b1;
                  wb_index <= req_rd_index;
                  wb_value <= srl_val;
               end
               LATEALU_OP_SRA: begin
                  wb_valid <= 1'b1;
                  wb_index <= req_rd_index;
                  wb_value <= sra_val;
               end
               LATEALU_OP_MULT: neg     <= req_a0[31] ^ req_a1[31];
               LATEALU_OP_MTHI: mult_hi <= req_a0;
               LATEALU_OP_MTLO: mult_lo <= req_a0;
               default:         err     <= 1'b1;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pipeline_latealu_ctrl.sv
// Self-checking bench: directed cases with literal expectations plus random
// traffic compared each cycle against a transaction-level model.
module tb_pipeline_latealu_ctrl;

   localparam int STEP      = 2;
   localparam int ITER      = 32 / STEP;
   localparam int BUSY_CYC  = ITER + 1;
   localparam logic [5:0] OP_SRL  = 6'b000010;
   localparam logic [5:0] OP_SRA  = 6'b000011;
   localparam logic [5:0] OP_MULT = 6'b000100;
   localparam logic [5:0] OP_MTHI = 6'b000101;
   localparam logic [5:0] OP_MTLO = 6'b000110;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [5:0]  req_op;
   logic [31:0] req_a0;
   logic [31:0] req_a1;
   logic [4:0]  req_rd_index;
   logic        req_flush;
   logic        hilo_read;
   logic        req_ready;
   logic        stall;
   logic        busy;
   logic        wb_valid;
   logic [4:0]  wb_index;
   logic [31:0] wb_value;
   logic [31:0] mult_hi;
   logic [31:0] mult_lo;
   logic        err;

   int checks   = 0;
   int failures = 0;

   // Model state
   int          m_busy_cnt;
   logic [63:0] m_pend;
   logic [31:0] m_hi, m_lo;
   logic        m_wb_valid, m_err;
   logic [4:0]  m_wb_index;
   logic [31:0] m_wb_value;

   pipeline_latealu_ctrl #(.MULT_STEP_BITS(STEP)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_op       (req_op),
      .req_a0       (req_a0),
      .req_a1       (req_a1),
      .req_rd_index (req_rd_index),
      .req_flush    (req_flush),
      .hilo_read    (hilo_read),
      .req_ready    (req_ready),
      .stall        (stall),
      .busy         (busy),
      .wb_valid     (wb_valid),
      .wb_index     (wb_index),
      .wb_value     (wb_value),
      .mult_hi      (mult_hi),
      .mult_lo      (mult_lo),
      .err          (err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy_cnt = 0;
      m_pend     = '0;
      m_hi       = '0;
      m_lo       = '0;
      m_wb_valid = 1'b0;
      m_err      = 1'b0;
      m_wb_index = '0;
      m_wb_value = '0;
   endtask

   // Advance the model across one rising edge using the currently driven inputs
   task automatic model_step();
      logic signed [63:0] sa, sb;
      logic accept;
      accept     = req_valid && (m_busy_cnt == 0) && !req_flush;
      m_wb_valid = 1'b0;
      m_err      = 1'b0;
      if (m_busy_cnt > 0) begin
         m_busy_cnt--;
         if (m_busy_cnt == 0) {m_hi, m_lo} = m_pend;
      end else if (accept) begin
         case (req_op)
            OP_SRL: begin
               m_wb_valid = 1'b1;
               m_wb_index = req_rd_index;
               m_wb_value = req_a0 >> req_a1[4:0];
            end
            OP_SRA: begin
               m_wb_valid = 1'b1;
               m_wb_index = req_rd_index;
               m_wb_value = $signed(req_a0) >>> req_a1[4:0];
            end
            OP_MULT: begin
               sa         = {{32{req_a0[31]}}, req_a0};
               sb         = {{32{req_a1[31]}}, req_a1};
               m_pend     = sa * sb;
               m_busy_cnt = BUSY_CYC;
            end
            OP_MTHI: m_hi = req_a0;
            OP_MTLO: m_lo = req_a0;
            default: m_err = 1'b1;
         endcase
      end
   endtask

   task automatic check_output();
      logic m_busy;
      m_busy = (m_busy_cnt > 0);
      check_val("busy",      64'(busy),      64'(m_busy));
      check_val("req_ready", 64'(req_ready), 64'(!m_busy));
      check_val("stall",     64'(stall),     64'(m_busy && (req_valid || hilo_read)));
      check_val("wb_valid",  64'(wb_valid),  64'(m_wb_valid));
      check_val("wb_index",  64'(wb_index),  64'(m_wb_index));
      check_val("wb_value",  64'(wb_value),  64'(m_wb_value));
      check_val("err",       64'(err),       64'(m_err));
      check_val("mult_hi",   64'(mult_hi),   64'(m_hi));
      check_val("mult_lo",   64'(mult_lo),   64'(m_lo));
   endtask

   task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a0,
                        input logic [31:0] a1, input logic [4:0] rd,
                        input logic fl, input logic hr);
      req_valid    = v;
      req_op       = op;
      req_a0       = a0;
      req_a1       = a1;
      req_rd_index = rd;
      req_flush    = fl;
      hilo_read    = hr;
   endtask

   // Entered and left at posedge+1; checks the model at the negedge in between
   task automatic cycle();
      @(negedge clk);
      check_output();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic v, input logic [5:0] op, input logic [31:0] a0,
                                 input logic [31:0] a1, input logic [4:0] rd,
                                 input logic fl, input logic hr);
      drive(v, op, a0, a1, rd, fl, hr);
      cycle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic run_mult(input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      apply_stimulus(1'b1, OP_MULT, a0, a1, 5'd0, 1'b0, 1'b0);
      idle(BUSY_CYC - 1);
      check_val("mult_busy_last", 64'(busy), 64'd1);
      idle(1);
      check_val("mult_busy_done", 64'(busy), 64'd0);
      check_val("mult_hi_lit",    64'(mult_hi), 64'(exp_hi));
      check_val("mult_lo_lit",    64'(mult_lo), 64'(exp_lo));
   endtask

   initial begin
      logic [5:0]  op;
      logic [31:0] a1;
      int          r;
      drive(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
      rst = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_output();
      rst = 1'b1;

      // Shifts
      apply_stimulus(1'b1, OP_SRA, 32'h80000010, 32'd4, 5'd9, 1'b0, 1'b0);
      check_val("sra_valid", 64'(wb_valid), 64'd1);
      check_val("sra_index", 64'(wb_index), 64'd9);
      check_val("sra_value", 64'(wb_value), 64'hF8000001);
      apply_stimulus(1'b1, OP_SRL, 32'h80000010, 32'd4, 5'd9, 1'b0, 1'b0);
      check_val("srl_value", 64'(wb_value), 64'h08000001);
      apply_stimulus(1'b1, OP_SRL, 32'hDEADBEEF, 32'hFFFFFFE0, 5'd0, 1'b0, 1'b0);
      check_val("shift0_value", 64'(wb_value), 64'hDEADBEEF);
      check_val("shift0_index", 64'(wb_index), 64'd0);
      idle(1);
      check_val("wb_pulse_end", 64'(wb_valid), 64'd0);

      // Multiplies including the most-negative operand
      run_mult(32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
      run_mult(32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
      run_mult(32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000);

      // Hazards during a multiply: reads stall, flushed mtlo dropped, mthi waits
      apply_stimulus(1'b1, OP_MULT, 32'd5, 32'd6, 5'd0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(1'b1, OP_MTLO, 32'h0000DEAD, 32'd0, 5'd0, 1'b1, 1'b1);
         check_val("stall_read", 64'(stall), 64'd1);
         check_val("hi_held", 64'(mult_hi), 64'hC0000000);
      end
      for (int i = 0; i < 15; i++) apply_stimulus(1'b1, OP_MTHI, 32'h1234, 32'd0, 5'd0, 1'b0, 1'b0);
      idle(1);
      check_val("mthi_after_mult", 64'(mult_hi), 64'h1234);
      check_val("lo_after_mult",   64'(mult_lo), 64'd30);

      // Unknown op
      apply_stimulus(1'b1, 6'h3F, 32'h55, 32'h1, 5'd3, 1'b0, 1'b0);
      check_val("err_pulse", 64'(err), 64'd1);
      check_val("err_no_wb", 64'(wb_valid), 64'd0);
      idle(1);
      check_val("err_clear", 64'(err), 64'd0);

      // Asynchronous reset mid-multiply
      apply_stimulus(1'b1, OP_MULT, 32'h12345678, 32'h9ABCDEF0, 5'd0, 1'b0, 1'b0);
      idle(4);
      #1;
      rst = 1'b0;
      #1;
      check_val("rst_busy", 64'(busy),    64'd0);
      check_val("rst_hi",   64'(mult_hi), 64'd0);
      check_val("rst_lo",   64'(mult_lo), 64'd0);
      check_val("rst_wbv",  64'(wb_value), 64'd0);
      check_val("rst_wbi",  64'(wb_index), 64'd0);
      model_reset();
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      idle(BUSY_CYC + 2);

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1:    op = OP_SRL;
            2, 3:    op = OP_SRA;
            4:       op = OP_MULT;
            5, 6:    op = OP_MTHI;
            7:       op = OP_MTLO;
            default: op = ($urandom_range(0, 1) == 0) ? 6'h3F : 6'($urandom_range(7, 62));
         endcase
         a1 = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         apply_stimulus($urandom_range(0, 3) != 0, op, $urandom, a1, 5'($urandom),
                        $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
      end
      idle(BUSY_CYC + 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipeline_latealu_ctrl.md
Name: pipeline_latealu_ctrl

Overview:
Sequences the LateALU resource fed by the ALU stage: variable shifts (srl/sra), signed 32x32 multiply, and mthi/mtlo writes to the architectural HI/LO pair. Shifts complete in one cycle. Multiply runs iteratively over several cycles while busy is held. The block owns HI/LO, serves mfhi/mflo reads, and raises stall whenever a new request or a HI/LO read would race an in-flight multiply.

Parameters:
MULT_STEP_BITS, 2, multiplier bits retired per iteration; legal values are 1, 2, 4, 8; ITER = 32/MULT_STEP_BITS.

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  LateALU request from the ALU stage
req_op  in  6  operation: 000010 srl, 000011 sra, 000100 mult, 000101 mthi, 000110 mtlo
req_a0  in  32  operand 0; shift source or multiplicand/mthi/mtlo value
req_a1  in  32  operand 1; shift amount in [4:0], or multiplier
req_rd_index  in  5  destination register for shift results
req_flush  in  1  discard the request presented this cycle
hilo_read  in  1  ALU stage is executing mfhi/mflo this cycle
req_ready  out  1  high when the block accepts a request (= !busy)
stall  out  1  combinational: busy && (req_valid || hilo_read)
busy  out  1  multiply in progress
wb_valid  out  1  one-cycle pulse: shift result valid
wb_index  out  5  shift destination register
wb_value  out  32  shift result
mult_hi  out  32  architectural HI
mult_lo  out  32  architectural LO
err  out  1  one-cycle pulse: unknown op accepted

Behaviour:
- Reset (rst=0, async): state IDLE; busy, wb_valid, err = 0; wb_index, wb_value, mult_hi, mult_lo = 0; iteration counter and accumulators = 0.
- Accept = req_valid && req_ready && !req_flush, sampled at a rising edge. Requests not accepted are dropped; upstream holds them while stall is high.
- A flushed request has no effect, produces no wb_valid pulse, and does not set busy.
- srl/sra: wb_valid=1 at the edge after accept.
  - wb_value = a0 >> a1[4:0], logical for srl, arithmetic for sra.
  - wb_index = req_rd_index, passed through even when it is 0.
  - Shift by 0 returns a0 unchanged.
- mthi/mtlo: at the edge after accept, mult_hi (or mult_lo) = a0; the other register is unchanged. No wb pulse.
- Unknown op: err=1 for one cycle. No other state changes.
- wb_valid and err are deasserted one cycle after assertion unless a new qualifying accept occurs.
- Multiply FSM, states IDLE -> MUL_RUN -> MUL_FIX -> IDLE:
  - IDLE, mult accepted (edge E0):
    - latch |a0| and |a1| as 32-bit unsigned; 0x80000000 maps to 2^31 with no overflow.
    - latch neg = a0[31]^a1[31].
    - clear the 64-bit accumulator; counter = 0; busy=1.
  - MUL_RUN, edges E1..E_ITER:
    - add |a0| * (next MULT_STEP_BITS LSBs of |a1|), shifted by counter*MULT_STEP_BITS, to the accumulator.
    - counter increments; the last iteration moves the FSM to MUL_FIX.
  - MUL_FIX, edge E_ITER+1:
    - {mult_hi, mult_lo} = neg ? -acc : acc, in 64-bit two's complement.
    - busy=0; state IDLE.
  - busy is high for exactly ITER+1 cycles; with the default, that is 17.
  - HI/LO hold their old values until the MUL_FIX edge.
- HI/LO reads: mult_hi and mult_lo always show the committed values. hilo_read while busy asserts stall, so a stale value is never consumed.
- req_ready = 0 throughout MUL_RUN and MUL_FIX. Shift, mthi and mtlo requests issued during a multiply wait for it to finish.
- Reset mid-multiply: abort immediately. HI/LO return to 0 and no partial result is committed.
- Same-cycle request with req_flush=1 while busy: no effect; the multiply continues.

Decomposition:
- Shared package pipeline_latealu_pkg holds:
  - localparams LATEALU_OP_SRL/SRA/MULT/MTHI/MTLO, 6-bit, matching the ALU stage encoding;
  - FSM state encoding IDLE/MUL_RUN/MUL_FIX.
- One natural sub-module, latealu_iter_mult: the unsigned iterative datapath (operand regs, accumulator, counter, done flag).
- The FSM, sign handling, shifter and HI/LO stay in the top level.

Test Plan:
- Reset applied mid-operation with rst=0 asynchronously -> all outputs 0 before the next clk edge; FSM returns to IDLE.
- sra a0=0x80000010, a1=4, rd=9 -> next cycle wb_valid=1, wb_index=9, wb_value=0xF8000001. srl with the same operands -> wb_value=0x08000001.
- mult a0=0xFFFFFFFD (-3), a1=7 -> busy for 17 cycles; then mult_hi=0xFFFFFFFF, mult_lo=0xFFFFFFEB.
- mult 0x80000000 * 0x80000000 -> mult_hi=0x40000000, mult_lo=0x00000000. Also 0x7FFFFFFF * 0x80000000 -> mult_hi=0xC0000000, mult_lo=0x80000000.
- During a multiply:
  - hilo_read=1 -> stall=1 and mult_hi/mult_lo unchanged until the MUL_FIX edge;
  - mthi a0=0x1234 held with req_valid -> accepted only once busy=0, then mult_hi=0x1234;
  - req_flush with mtlo -> mult_lo unchanged.
- req_op=0x3F -> err pulse for exactly 1 cycle; no wb pulse, busy stays 0, HI/LO unchanged.
